ark_stream_stage: RTL
=====================

Name: ark_stream_stage

Overview:
- Registered, handshaked AddRoundKey stage for the AES datapath.
- Holds a bank of NUM_ROUNDS+1 round keys, loaded through a write port.
- XORs each incoming state with the round key selected by the state's round tag.
- Returns the result one cycle later on a valid/ready output, with error flagging for unloaded or out-of-range keys.
- Sits between the round-function stages (SubBytes/ShiftRows/MixColumns) and the next round, or at cipher input/output.

Parameters:
- DATA_W, 128, state/key width in bits; must be a multiple of 8.
- NUM_ROUNDS, 10, last round index; the bank holds indices 0..NUM_ROUNDS (10/12/14 for AES-128/192/256).
- RIDX_W, 4, round-index width; must satisfy 2**RIDX_W > NUM_ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_wr_en  in  1  write round key this cycle.
- key_wr_idx  in  RIDX_W  round index to write.
- key_wr_data  in  DATA_W  round key value.
- key_clr  in  1  synchronous clear of all key-loaded flags.
- in_valid  in  1  input state valid.
- in_ready  out  1  stage can accept input.
- in_state  in  DATA_W  state bytes.
- in_round  in  RIDX_W  round tag selecting the key.
- in_bypass  in  1  pass the state through without XOR.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_state  out  DATA_W  result.
- out_round  out  RIDX_W  round tag, forwarded.
- out_err  out  1  key missing or index out of range for this beat.
- keys_loaded  out  1  all indices 0..NUM_ROUNDS loaded.

Behaviour:
- Interface fact: one clock; reset is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_state=0, out_round=0, out_err=0.
  - All key-loaded flags=0, so keys_loaded=0.
  - Key bank contents are don't-care and need no reset.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - An accept occurs when in_valid && in_ready.
  - Once out_valid=1, out_state, out_round and out_err stay stable until out_ready=1.
  - Full throughput: one beat per cycle when out_ready is held 1.
- Latency: exactly 1 cycle from accept to out_valid=1.
- Datapath on accept (bytewise XOR, byte i = bits [8i+7:8i]):
  - in_bypass=1: out_state=in_state, out_err=0.
  - in_round > NUM_ROUNDS: out_state=in_state, out_err=1.
  - Key flag for in_round clear: out_state=in_state, out_err=1.
  - Otherwise: out_state=in_state XOR key[in_round], out_err=0.
- Output register update:
  - On out_ready && !accept: out_valid falls to 0; data holds its last value.
  - On accept: the register loads the new beat and out_valid=1.
- Key writes:
  - key_wr_en with key_wr_idx <= NUM_ROUNDS writes the bank and sets that index's flag next edge.
  - key_wr_idx > NUM_ROUNDS is ignored.
- Write/read collision (same cycle, same index): the accepted beat uses the OLD key (read-before-write). If the flag was clear, out_err=1.
- key_clr:
  - Clears all flags next edge; bank data is unchanged.
  - key_clr together with key_wr_en: clear wins, and the written index's flag stays 0.
  - A beat already in the output register is unaffected.
- keys_loaded is the AND of flags 0..NUM_ROUNDS, registered from the flags (no extra latency beyond the flag update).
- Reset mid-transfer drops the pending output beat with no partial output.

Decomposition:
- Shared package ark_pkg:
  - AES_BLOCK_W=128.
  - AES_NR_128/192/256 = 10/12/14.
  - Function clog2-based RIDX_W helper.
  - Typedef of the state as a 16-byte array.
- Sub-module ark_key_bank: holds the key storage and loaded flags, the write port, the combinational read by index, read-before-write, key_clr priority, and keys_loaded.
- The top level holds the XOR, error selection, output register and handshake.

Test Plan:
- FIPS-197 App. B round 0: load key[0]=2b7e151628aed2a6abf7158809cf4f3c, send state 3243f6a8885a308d313198a2e0370734 with round 0 -> one cycle later out_state=193de3bea0f4e22b9ac68d2ae9f84808, out_err=0.
- Backpressure: out_ready=0 for 3 cycles with 2 beats offered -> first beat held stable and in_ready=0; after release, beats appear in order with no loss or duplication.
- Missing/out-of-range key: round 5 unloaded, then round 15 with NUM_ROUNDS=10 -> out_state=in_state, out_err=1 both times.
- Collision: key[3]=A loaded, write B to index 3 in the same cycle as a round-3 accept -> result uses A; the next round-3 beat uses B.
- Load all 11 keys -> keys_loaded=1; pulse key_clr with key_wr_en -> keys_loaded=0 and all flags clear.
- Assert rst while out_valid=1 with out_ready=0 -> out_valid=0 immediately, keys_loaded=0, bypass beat after reset passes unchanged.

Source files
------------

// File: rtl/ark_pkg.sv
// ark_pkg: shared AES constants, state typedef and round-index width helper.
package ark_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;
  typedef logic [15:0][7:0] aes_state_t;
  function automatic int ridx_w(input int nr);
    return $clog2(nr + 1);
  endfunction
endpackage

// File: rtl/ark_key_bank.sv
// ark_key_bank: round-key storage with per-index loaded flags and read-before-write lookup.
module ark_key_bank import ark_pkg::*; #(
  parameter int DATA_W     = AES_BLOCK_W,
  parameter int NUM_ROUNDS = AES_NR_128,
  parameter int RIDX_W     = ridx_w(NUM_ROUNDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [RIDX_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic [RIDX_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_key,
  output logic              rd_ok,
  output logic              keys_loaded
);
  localparam logic [RIDX_W-1:0] LAST = RIDX_W'(NUM_ROUNDS);
  logic [DATA_W-1:0] bank_q [NUM_ROUNDS+1];
  logic [NUM_ROUNDS:0] flags_d, flags_q;
  logic loaded_d, loaded_q;
  logic wr_ok, rd_in;
  logic [RIDX_W-1:0] rd_sel;
  always_comb begin
    wr_ok = wr_en && wr_idx <= LAST;
    rd_in = rd_idx <= LAST;
    rd_sel = rd_in ? rd_idx : '0;
    rd_key = bank_q[rd_sel];
    rd_ok = rd_in && flags_q[rd_sel];
    flags_d = flags_q;
    if (wr_ok) flags_d[wr_idx] = 1'b1;
    if (clr) flags_d = '0;
    loaded_d = &flags_d;
  end
  // Bank data is never reset; only the flags decide whether a key is usable.
  always_ff @(posedge clk)
    if (wr_ok) bank_q[wr_idx] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flags_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      loaded_q <= loaded_d;
    end
  assign keys_loaded = loaded_q;
endmodule

// File: rtl/ark_stream_stage.sv
// ark_stream_stage: registered valid/ready AddRoundKey stage keyed by each beat's round tag.
module ark_stream_stage import ark_pkg::*; #(
  parameter int DATA_W     = AES_BLOCK_W,
  parameter int NUM_ROUNDS = AES_NR_128,
  parameter int RIDX_W     = ridx_w(NUM_ROUNDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [RIDX_W-1:0] key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              key_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic [RIDX_W-1:0] in_round,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_state,
  output logic [RIDX_W-1:0] out_round,
  output logic              out_err,
  output logic              keys_loaded
);
  logic [DATA_W-1:0] rd_key, out_state_d, out_state_q;
  logic [RIDX_W-1:0] out_round_d, out_round_q;
  logic rd_ok, accept, out_valid_d, out_valid_q, out_err_d, out_err_q;
  ark_key_bank #(.DATA_W(DATA_W), .NUM_ROUNDS(NUM_ROUNDS), .RIDX_W(RIDX_W)) u_bank (
    .clk(clk), .rst(rst), .wr_en(key_wr_en), .wr_idx(key_wr_idx), .wr_data(key_wr_data),
    .clr(key_clr), .rd_idx(in_round), .rd_key(rd_key), .rd_ok(rd_ok), .keys_loaded(keys_loaded)
  );
  // Missing or out-of-range keys pass the state through untouched but flag the beat.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept = in_valid && in_ready;
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_state_d = !accept ? out_state_q : (in_bypass || !rd_ok) ? in_state : in_state ^ rd_key;
    out_err_d = accept ? !in_bypass && !rd_ok : out_err_q;
    out_round_d = accept ? in_round : out_round_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_round_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_round_q <= out_round_d;
      out_err_q <= out_err_d;
    end
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_round = out_round_q;
  assign out_err = out_err_q;
endmodule
